grf: RTL and testbench
======================

GRF -- requirements
Module: grf

Interface
REQ-001 Parameter BYPASS, default 1, meaning: 1 enables internal write-to-read forwarding; 0 makes reads return stored contents only.
REQ-002 clk  input  1  pipeline clock; all register writes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; clears every register.
REQ-004 regwrite  input  1  W-stage write enable, from the W-stage main control.
REQ-005 wdctr  input  2  W-stage write-data select: 00 ALU result, 01 memory data, 10 PC+8, 11 reserved.
REQ-006 a1  input  5  read port 1 address (D-stage rs).
REQ-007 a2  input  5  read port 2 address (D-stage rt).
REQ-008 a3  input  5  write address from the W stage.
REQ-009 aluoutW  input  32  ALU result carried into W.
REQ-010 memdataW  input  32  load data carried into W, already extended for lh/lb.
REQ-011 pc8W  input  32  link value (PC+8) for jal/bgezal.
REQ-012 rd1  output  32  read data for a1.
REQ-013 rd2  output  32  read data for a2.
REQ-014 wd  output  32  selected write data, exported for W-to-E/M forwarding paths.

Function
REQ-015 Storage: 32 registers x 32 bits; register 0 is hardwired to zero, with no storage or a never-written entry.
REQ-016 Write-data mux (combinational):
- wd = aluoutW when wdctr=00
- wd = memdataW when wdctr=01
- wd = pc8W when wdctr=10
- wd = 32'h0000_0000 when wdctr=11
REQ-017 Write: on the rising edge of clk, when reset=0, regwrite=1 and a3!=0, register[a3] loads wd; otherwise all registers hold.
REQ-018 A write with a3=0 is silently discarded; register 0 reads as 0 at all times.
REQ-019 Read timing: rd1 and rd2 are combinational functions of the addresses and state, with zero-cycle latency.
REQ-020 Read with BYPASS=1:
- rd1 = wd if regwrite=1, a3!=0 and a1==a3
- rd1 = 0 if a1=0
- otherwise rd1 = register[a1]
- rd2 follows the same rules using a2.
REQ-021 Read with BYPASS=0: rdN = register[aN], or 0 when aN=0.
REQ-022 Same-cycle read and write to one address: the new value appears in the same cycle when BYPASS=1; when BYPASS=0, the old value appears until the edge and the new value after it.
REQ-023 a1==a2: both ports return identical data in every case.
REQ-024 wdctr=11 with regwrite=1 writes zero to register[a3]; this case is legal but unused by the decoder.
REQ-025 X-free: unknown wdctr or address values never corrupt register 0.

Reset
REQ-026 reset=1 asynchronously clears all registers to 0, without waiting for a clock edge.
REQ-027 While reset=1, rd1=rd2=0 for every address.
REQ-027a While reset=1, bypass is disabled for rd1 and rd2.
REQ-028 While reset=1, wd still follows REQ-016.
REQ-029 Reset asserted in the same cycle as a write: reset wins, and the target register is 0 afterwards.
REQ-030 After reset deasserts, the first write takes effect on the next rising edge.

Verification
REQ-031 Basic write and read: reset; regwrite=1, a3=5, wdctr=00, aluoutW=32'h1234_5678; clock; then a1=5 -> rd1=32'h1234_5678.
REQ-032 Zero register protected: regwrite=1, a3=0, aluoutW=32'hFFFF_FFFF; clock; a1=0 -> rd1=0, also through the bypass path in the same cycle.
REQ-033 Source selection:
- wdctr=01, memdataW=32'hFFFF_FF80, a3=8; clock -> register[8]=32'hFFFF_FF80
- wdctr=10, pc8W=32'h0000_3008, a3=31; clock -> register[31]=32'h0000_3008
REQ-034 Bypass: register[9]=32'hA, then in the same cycle regwrite=1, a3=9, aluoutW=32'hB, a1=a2=9 -> rd1=rd2=32'hB before the edge (BYPASS=1); rd1=rd2=32'hA before the edge (BYPASS=0).
REQ-035 Asynchronous reset mid-operation: registers 1..31 loaded with nonzero data; pulse reset between clock edges -> all reads return 0 immediately; a write pending at the next edge with reset high is lost.
REQ-036 Disabled write: regwrite=0, a3=12, aluoutW=32'h55; clock -> register[12] unchanged at 0.

Source files
------------

// File: rtl/grf.sv
// General register file: 32 x 32-bit registers with register 0 hardwired to zero,
// a W-stage write-data mux and optional same-cycle write-to-read forwarding.
module grf #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regwrite,
    input  logic [1:0]  wdctr,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] aluoutW,
    input  logic [31:0] memdataW,
    input  logic [31:0] pc8W,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] wd
);

    logic [31:0] regs_reg [0:31];
    logic        hit1;
    logic        hit2;

    // Unknown or reserved selects fall through to zero.
    always_comb begin
        wd = 32'h0000_0000;
        case (wdctr)
            2'b00:   wd = aluoutW;
            2'b01:   wd = memdataW;
            2'b10:   wd = pc8W;
            default: wd = 32'h0000_0000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_reg[gi] = 32'h0000_0000;
            end else begin : g_store
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        regs_reg[gi] <= 32'h0000_0000;
                    end else if (regwrite && (a3 == 5'(gi))) begin
                        regs_reg[gi] <= wd;
                    end
                end
            end
        end
    endgenerate

    // Forwarding only applies to real writes; a3=0 never forwards.
    assign hit1 = BYPASS && regwrite && (a3 != 5'd0) && (a1 == a3);
    assign hit2 = BYPASS && regwrite && (a3 != 5'd0) && (a2 == a3);

    assign rd1 = reset         ? 32'h0000_0000 :
                 (a1 == 5'd0)  ? 32'h0000_0000 :
                 hit1          ? wd            : regs_reg[a1];
    assign rd2 = reset         ? 32'h0000_0000 :
                 (a2 == 5'd0)  ? 32'h0000_0000 :
                 hit2          ? wd            : regs_reg[a2];

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: one instance with forwarding, one without,
// both driven identically and compared against an array-based reference.
module tb_grf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        regwrite = 1'b0;
    logic [1:0]  wdctr = 2'b00;
    logic [4:0]  a1 = 5'd0, a2 = 5'd0, a3 = 5'd0;
    logic [31:0] aluoutW = 32'h0, memdataW = 32'h0, pc8W = 32'h0;
    logic [31:0] rd1, rd2, wd;
    logic [31:0] rd1_nb, rd2_nb, wd_nb;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] model [0:31];

    grf #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .regwrite(regwrite), .wdctr(wdctr),
        .a1(a1), .a2(a2), .a3(a3), .aluoutW(aluoutW), .memdataW(memdataW),
        .pc8W(pc8W), .rd1(rd1), .rd2(rd2), .wd(wd)
    );

    grf #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .regwrite(regwrite), .wdctr(wdctr),
        .a1(a1), .a2(a2), .a3(a3), .aluoutW(aluoutW), .memdataW(memdataW),
        .pc8W(pc8W), .rd1(rd1_nb), .rd2(rd2_nb), .wd(wd_nb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_wd();
        case (wdctr)
            2'b00:   return aluoutW;
            2'b01:   return memdataW;
            2'b10:   return pc8W;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_rd(input logic [4:0] a, input bit byp);
        if (reset || a == 5'd0) return 32'h0;
        if (byp && regwrite && a3 != 5'd0 && a == a3) return ref_wd();
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // Drive a cycle's inputs just after the falling edge.
    task automatic drive(input logic rw, input logic [1:0] sel, input logic [4:0] w,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        @(negedge clk);
        regwrite = rw; wdctr = sel; a3 = w; a1 = r1; a2 = r2;
        aluoutW = alu; memdataW = mem; pc8W = pc;
        #1;
    endtask

    // Commit the pending write to the model across the rising edge.
    task automatic tick();
        bit          do_wr;
        logic [4:0]  addr;
        logic [31:0] val;
        do_wr = !reset && regwrite && (a3 != 5'd0);
        addr  = a3;
        val   = ref_wd();
        @(posedge clk);
        if (do_wr) model[addr] = val;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] e;
        clear_model();
        drive(1'b1, 2'b00, 5'd7, 5'd7, 5'd7, 32'hDEAD_BEEF, 32'h1, 32'h2);
        n_cmp++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_bypass_rd1 got=%h exp=%h", rd1, 32'h0); end
        n_cmp++;
        if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_bypass_rd2 got=%h exp=%h", rd2, 32'h0); end
        n_cmp++;
        if (wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_wd got=%h exp=%h", wd, 32'hDEAD_BEEF); end
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 5'd7, 5'd7, 32'h0, 32'h0, 32'h0);
        e = 32'h0;
        n_cmp++;
        if (rd1 !== e) begin n_fail++; $display("FAIL reset_write_lost got=%h exp=%h", rd1, e); end
        $display("test_reset: write under reset discarded, rd1=%h", rd1);
    endtask

    task automatic test_basic();
        drive(1'b1, 2'b00, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 32'h0, 32'h0);
        tick();
        drive(1'b0, 2'b00, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_rd1 got=%h exp=%h", rd1, 32'h1234_5678); end
        n_cmp++;
        if (rd1_nb !== 32'h1234_5678) begin n_fail++; $display("FAIL basic_rd1_nb got=%h exp=%h", rd1_nb, 32'h1234_5678); end
        $display("test_basic: r5 -> %h", rd1);
    endtask

    task automatic test_zero();
        drive(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL zero_bypass got=%h exp=%h", rd1, 32'h0); end
        tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL zero_after got=%h exp=%h", rd1, 32'h0); end
        drive(1'b1, 2'bxx, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (rd2 !== 32'h0) begin n_fail++; $display("FAIL zero_xsel got=%h exp=%h", rd2, 32'h0); end
        $display("test_zero: r0 -> %h", rd1);
    endtask

    task automatic test_sources();
        drive(1'b1, 2'b01, 5'd8, 5'd0, 5'd0, 32'h1111_1111, 32'hFFFF_FF80, 32'h2222_2222);
        tick();
        drive(1'b1, 2'b10, 5'd31, 5'd8, 5'd0, 32'h1111_1111, 32'h3333_3333, 32'h0000_3008);
        tick();
        drive(1'b1, 2'b11, 5'd5, 5'd8, 5'd31, 32'h1111_1111, 32'h3333_3333, 32'h4444_4444);
        n_cmp++;
        if (rd1 !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL src_mem got=%h exp=%h", rd1, 32'hFFFF_FF80); end
        n_cmp++;
        if (rd2 !== 32'h0000_3008) begin n_fail++; $display("FAIL src_pc8 got=%h exp=%h", rd2, 32'h0000_3008); end
        n_cmp++;
        if (wd !== 32'h0) begin n_fail++; $display("FAIL src_rsvd_wd got=%h exp=%h", wd, 32'h0); end
        tick();
        drive(1'b0, 2'b00, 5'd0, 5'd5, 5'd5, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL src_rsvd_write got=%h exp=%h", rd1, 32'h0); end
        $display("test_sources: r8=%h r31=%h r5=%h", model[8], model[31], rd1);
    endtask

    task automatic test_bypass();
        drive(1'b1, 2'b00, 5'd9, 5'd0, 5'd0, 32'hA, 32'h0, 32'h0);
        tick();
        drive(1'b1, 2'b00, 5'd9, 5'd9, 5'd9, 32'hB, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'hB || rd2 !== 32'hB) begin
            n_fail++; $display("FAIL bypass_on got=%h/%h exp=%h", rd1, rd2, 32'hB);
        end
        n_cmp++;
        if (rd1_nb !== 32'hA || rd2_nb !== 32'hA) begin
            n_fail++; $display("FAIL bypass_off got=%h/%h exp=%h", rd1_nb, rd2_nb, 32'hA);
        end
        tick();
        n_cmp++;
        if (rd1_nb !== 32'hB) begin n_fail++; $display("FAIL bypass_off_after got=%h exp=%h", rd1_nb, 32'hB); end
        $display("test_bypass: fwd=%h nofwd_after=%h", rd1, rd1_nb);
    endtask

    task automatic test_disabled();
        drive(1'b0, 2'b00, 5'd12, 5'd12, 5'd0, 32'h55, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL disabled_bypass got=%h exp=%h", rd1, 32'h0); end
        tick();
        n_cmp++;
        if (rd1 !== 32'h0) begin n_fail++; $display("FAIL disabled_write got=%h exp=%h", rd1, 32'h0); end
        $display("test_disabled: r12=%h", rd1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 300; t++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                  $urandom, $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) a1 = a3;
            if ($urandom_range(0, 5) == 0) a2 = a1;
            #1;
            n_cmp++;
            if (rd1 !== ref_rd(a1, 1'b1)) begin n_fail++; $display("FAIL rand_rd1 a1=%0d got=%h exp=%h", a1, rd1, ref_rd(a1, 1'b1)); end
            n_cmp++;
            if (rd2 !== ref_rd(a2, 1'b1)) begin n_fail++; $display("FAIL rand_rd2 a2=%0d got=%h exp=%h", a2, rd2, ref_rd(a2, 1'b1)); end
            n_cmp++;
            if (rd1_nb !== ref_rd(a1, 1'b0)) begin n_fail++; $display("FAIL rand_rd1_nb a1=%0d got=%h exp=%h", a1, rd1_nb, ref_rd(a1, 1'b0)); end
            n_cmp++;
            if (rd2_nb !== ref_rd(a2, 1'b0)) begin n_fail++; $display("FAIL rand_rd2_nb a2=%0d got=%h exp=%h", a2, rd2_nb, ref_rd(a2, 1'b0)); end
            n_cmp++;
            if (wd !== ref_wd() || wd_nb !== ref_wd()) begin n_fail++; $display("FAIL rand_wd got=%h/%h exp=%h", wd, wd_nb, ref_wd()); end
            $display("rand %0d: we=%0b sel=%0d a3=%0d a1=%0d a2=%0d rd1=%h rd2=%h", t, regwrite, wdctr, a3, a1, a2, rd1, rd2);
            tick();
        end
    endtask

    task automatic test_async_reset();
        int bad;
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 2'b00, 5'(r), 5'd0, 5'd0, 32'h1000_0000 + 32'(r), 32'h0, 32'h0);
            tick();
        end
        drive(1'b0, 2'b00, 5'd0, 5'd17, 5'd31, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'h1000_0011) begin n_fail++; $display("FAIL async_preload got=%h exp=%h", rd1, 32'h1000_0011); end
        // Assert reset between edges and check without any clock edge.
        @(posedge clk); #2;
        reset = 1'b1;
        clear_model();
        #1;
        bad = 0;
        for (int r = 0; r < 32; r++) begin
            a1 = 5'(r); a2 = 5'(31 - r); #0.1;
            if (rd1 !== 32'h0 || rd2 !== 32'h0 || rd1_nb !== 32'h0 || rd2_nb !== 32'h0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_fail++; $display("FAIL async_clear got=%0d nonzero exp=0", bad); end
        drive(1'b1, 2'b00, 5'd20, 5'd20, 5'd0, 32'hCAFE_F00D, 32'h0, 32'h0);
        tick();
        reset = 1'b0;
        drive(1'b0, 2'b00, 5'd0, 5'd20, 5'd0, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (rd1 !== 32'h0 || rd1_nb !== 32'h0) begin n_fail++; $display("FAIL async_write_lost got=%h exp=%h", rd1_nb, 32'h0); end
        drive(1'b1, 2'b00, 5'd20, 5'd0, 5'd0, 32'h0BAD_CAFE, 32'h0, 32'h0);
        tick();
        drive(1'b0, 2'b00, 5'd0, 5'd20, 5'd0, 32'h0, 32'h0, 32'h0);
        n_cmp++;
        if (rd1_nb !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL post_reset_write got=%h exp=%h", rd1_nb, 32'h0BAD_CAFE); end
        $display("test_async_reset: cleared, first write after reset r20=%h", rd1_nb);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_sources();
        test_bypass();
        test_disabled();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
